// File: rtl/vgachargen_pkg.sv
// Shared constants and types for the character-map memory path.
package vgachargen_pkg;

    localparam int         CH_MAP_ADDR_WIDTH    = 12;
    localparam int         COL_MAP_DATA_WIDTH   = 8;
    localparam logic [6:0] CH_H_PIXELS          = 7'd80;
    localparam logic [4:0] CH_V_PIXELS          = 5'd30;
    localparam int         CH_MAP_DEPTH         = int'(CH_H_PIXELS) * int'(CH_V_PIXELS);
    localparam int         MAP_ARB_STARVE_LIMIT = 16;

    // What the RAM port was used for; travels with the read data to steer the return.
    typedef enum logic [2:0] {
        TAG_NONE,
        TAG_DISP,
        TAG_BUS_RD,
        TAG_BUS_WR,
        TAG_BUS_ERR
    } map_arb_tag_e;

    function automatic logic map_addr_in_range(input logic [4:0] row, input logic [6:0] col);
        return (row < CH_V_PIXELS) && (col < CH_H_PIXELS);
    endfunction

endpackage

// File: rtl/vgachargen_map_arbiter.sv
// Character-map RAM arbiter: display reads own the port outright, a single held
// bus request fills the display-free cycles, and returns are steered by a tag pipeline.
module vgachargen_map_arbiter
    import vgachargen_pkg::*;
#(
    parameter int ADDR_W       = CH_MAP_ADDR_WIDTH,
    parameter int DATA_W       = COL_MAP_DATA_WIDTH,
    parameter int STARVE_LIMIT = MAP_ARB_STARVE_LIMIT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              disp_req_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic              disp_valid_o,
    output logic [DATA_W-1:0] disp_data_o,
    input  logic              bus_req_i,
    input  logic              bus_we_i,
    input  logic [ADDR_W-1:0] bus_addr_i,
    input  logic [DATA_W-1:0] bus_wdata_i,
    output logic              bus_ready_o,
    output logic              bus_done_o,
    output logic [DATA_W-1:0] bus_rdata_o,
    output logic              bus_err_o,
    output logic              bus_starve_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int               COL_W      = 7;
    localparam int               ROW_W      = 5;
    localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic              r_hold_valid;
    logic              r_hold_we;
    logic [ADDR_W-1:0] r_hold_addr;
    logic [DATA_W-1:0] r_hold_wdata;
    map_arb_tag_e      r_tag_s1;
    map_arb_tag_e      r_tag_s2;
    logic [DATA_W-1:0] r_disp_data;
    logic [DATA_W-1:0] r_bus_rdata;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_starve;

    logic              w_accept;
    logic              w_issue;
    logic              w_hold_in_range;
    map_arb_tag_e      w_tag_now;

    assign bus_ready_o     = ~rst_i & ~r_hold_valid;
    assign w_accept        = bus_req_i & bus_ready_o;
    assign w_issue         = ~rst_i & r_hold_valid & ~disp_req_i;
    assign w_hold_in_range = map_addr_in_range(r_hold_addr[COL_W +: ROW_W], r_hold_addr[0 +: COL_W]);

    always_comb begin
        // NOTE: every signal gets a default first, so no branch can leave one unassigned and infer a latch.
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = r_hold_addr;
        mem_wdata_o = r_hold_wdata;
        w_tag_now   = TAG_NONE;
        if (!rst_i && disp_req_i) begin
            mem_en_o   = 1'b1;
            mem_addr_o = disp_addr_i;
            w_tag_now  = TAG_DISP;
        end else if (w_issue) begin
            // An off-screen address still completes, but never touches the RAM.
            mem_en_o  = w_hold_in_range;
            mem_we_o  = w_hold_in_range & r_hold_we;
            w_tag_now = !w_hold_in_range ? TAG_BUS_ERR : (r_hold_we ? TAG_BUS_WR : TAG_BUS_RD);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            r_hold_valid <= 1'b0;
            r_hold_we    <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_wdata <= '0;
            r_tag_s1     <= TAG_NONE;
            r_tag_s2     <= TAG_NONE;
            r_disp_data  <= '0;
            r_bus_rdata  <= '0;
            r_starve_cnt <= '0;
            r_starve     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold_valid <= 1'b1;
                r_hold_we    <= bus_we_i;
                r_hold_addr  <= bus_addr_i;
                r_hold_wdata <= bus_wdata_i;
            end else if (w_issue) begin
                r_hold_valid <= 1'b0;
            end

            r_tag_s1 <= w_tag_now;
            r_tag_s2 <= r_tag_s1;
            case (r_tag_s1)
                TAG_DISP:    r_disp_data <= mem_rdata_i;
                TAG_BUS_RD:  r_bus_rdata <= mem_rdata_i;
                TAG_BUS_ERR: r_bus_rdata <= '0;
                default:     ;
            endcase

            if (w_issue) begin
                r_starve_cnt <= '0;
            end else if (r_hold_valid && r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
                if (r_starve_cnt == STARVE_MAX - 1'b1) begin
                    r_starve <= 1'b1;
                end
            end
        end
    end

    assign disp_valid_o = ~rst_i & (r_tag_s2 == TAG_DISP);
    assign disp_data_o  = rst_i ? '0 : r_disp_data;
    assign bus_done_o   = ~rst_i & (r_tag_s2 inside {TAG_BUS_RD, TAG_BUS_WR, TAG_BUS_ERR});
    assign bus_err_o    = ~rst_i & (r_tag_s2 == TAG_BUS_ERR);
    assign bus_rdata_o  = rst_i ? '0 : r_bus_rdata;
    assign bus_starve_o = r_starve;

endmodule

// File: tb/tb_vgachargen_map_arbiter.sv
// Bench for the character-map arbiter: directed scenarios plus a randomized run
// compared against an event-queue model of the arbitration rules.
module tb_vgachargen_map_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int LIMIT = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          disp_req_i;
    logic [AW-1:0] disp_addr_i;
    logic          disp_valid_o;
    logic [DW-1:0] disp_data_o;
    logic          bus_req_i;
    logic          bus_we_i;
    logic [AW-1:0] bus_addr_i;
    logic [DW-1:0] bus_wdata_i;
    logic          bus_ready_o;
    logic          bus_done_o;
    logic [DW-1:0] bus_rdata_o;
    logic          bus_err_o;
    logic          bus_starve_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    vgachargen_map_arbiter dut (
        .clk_i(clk), .rst_i(rst_i),
        .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i),
        .disp_valid_o(disp_valid_o), .disp_data_o(disp_data_o),
        .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i),
        .bus_ready_o(bus_ready_o), .bus_done_o(bus_done_o), .bus_rdata_o(bus_rdata_o),
        .bus_err_o(bus_err_o), .bus_starve_o(bus_starve_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
    );

    function automatic logic [DW-1:0] pattern(input int i);
        return DW'((i * 37 + 11) ^ (i >> 5));
    endfunction

    // External single-port RAM, 1-cycle read latency, preloaded on the first edge.
    logic [DW-1:0] ram [0:4095];
    bit            filled = 1'b0;
    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 4096; i++) ram[i] <= pattern(i);
            filled <= 1'b1;
        end else if (mem_en_o) begin
            if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
            mem_rdata <= ram[mem_addr_o];
        end
    end

    // ---------------- reference model ----------------
    typedef struct { int at; logic [DW-1:0] data; } disp_ev_t;
    typedef struct { int at; logic [DW-1:0] data; logic err; logic rd; } done_ev_t;

    disp_ev_t      q_disp[$];
    done_ev_t      q_done[$];
    logic [DW-1:0] ref_mem [0:4095];
    logic          m_pend, m_we, m_starve;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_disp_last, m_rdata_last;
    int            m_cnt;
    int            cyc, n_checks, n_errors;

    logic          e_ready, e_mem_en, e_mem_we, e_disp_valid, e_done, e_err, e_starve;
    logic [AW-1:0] e_mem_addr;
    logic [DW-1:0] e_mem_wdata, e_disp_data, e_rdata;

    function automatic logic in_map(input logic [AW-1:0] a);
        return ((int'(a) % 128) < 80) && ((int'(a) / 128) < 30);
    endfunction

    // Drives one cycle, forms the expected outputs of that cycle, advances the model, samples at negedge.
    task automatic run_cycle(input logic r, input logic dq, input logic [AW-1:0] da,
                             input logic bq, input logic bw, input logic [AW-1:0] ba,
                             input logic [DW-1:0] bd);
        logic issue, inr;
        @(posedge clk);
        #1;
        rst_i = r; disp_req_i = dq; disp_addr_i = da;
        bus_req_i = bq; bus_we_i = bw; bus_addr_i = ba; bus_wdata_i = bd;
        cyc++;
        issue        = !r && m_pend && !dq;
        inr          = in_map(m_addr);
        e_ready      = !r && !m_pend;
        e_mem_en     = !r && (dq || (issue && inr));
        e_mem_we     = !r && !dq && issue && inr && m_we;
        e_mem_addr   = dq ? da : m_addr;
        e_mem_wdata  = m_wdata;
        e_disp_valid = 1'b0;
        e_done       = 1'b0;
        e_err        = 1'b0;
        e_starve     = m_starve;
        if (r) begin
            e_disp_data = '0;
            e_rdata     = '0;
        end else begin
            e_disp_data = m_disp_last;
            e_rdata     = m_rdata_last;
            if (q_disp.size() > 0 && q_disp[0].at == cyc) begin
                e_disp_valid = 1'b1;
                e_disp_data  = q_disp[0].data;
                m_disp_last  = e_disp_data;
                void'(q_disp.pop_front());
            end
            if (q_done.size() > 0 && q_done[0].at == cyc) begin
                e_done = 1'b1;
                e_err  = q_done[0].err;
                if (q_done[0].rd || q_done[0].err) e_rdata = q_done[0].data;
                m_rdata_last = e_rdata;
                void'(q_done.pop_front());
            end
        end
        if (r) begin
            q_disp.delete(); q_done.delete();
            m_pend = 1'b0; m_cnt = 0; m_starve = 1'b0;
            m_disp_last = '0; m_rdata_last = '0;
        end else begin
            if (dq) q_disp.push_back('{at: cyc + 2, data: ref_mem[da]});
            if (issue) begin
                if (inr && m_we) ref_mem[m_addr] = m_wdata;
                q_done.push_back('{at: cyc + 2, data: (inr && !m_we) ? ref_mem[m_addr] : '0,
                                   err: !inr, rd: inr && !m_we});
                m_pend = 1'b0;
                m_cnt  = 0;
            end else if (m_pend) begin
                if (m_cnt < LIMIT) m_cnt++;
                if (m_cnt == LIMIT) m_starve = 1'b1;
            end
            if (bq && e_ready) begin
                m_pend = 1'b1; m_we = bw; m_addr = ba; m_wdata = bd;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            run_cycle(1'b1, 1'b1, 12'h005, 1'b1, 1'b1, 12'h005, 8'hFF);
            n_checks++; if (bus_ready_o !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", bus_ready_o); end
            n_checks++; if (mem_en_o !== 1'b0) begin n_errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_en_o); end
            n_checks++; if ({disp_valid_o, bus_done_o, bus_err_o, bus_starve_o} !== 4'b0) begin
                n_errors++; $display("FAIL reset_flags: got %b expected 0000", {disp_valid_o, bus_done_o, bus_err_o, bus_starve_o}); end
            n_checks++; if ({disp_data_o, bus_rdata_o} !== 16'h0) begin
                n_errors++; $display("FAIL reset_data: got %h expected 0000", {disp_data_o, bus_rdata_o}); end
        end
        idle(2);
    endtask

    task automatic test_disp_read();
        run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 12'h005, 8'h41);
        idle(4);
        for (int k = 0; k < 5; k++) begin
            run_cycle(1'b0, k == 0, 12'h005, 1'b0, 1'b0, '0, '0);
            if (k == 0) begin
                n_checks++; if ({mem_en_o, mem_we_o, mem_addr_o} !== {2'b10, 12'h005}) begin
                    n_errors++; $display("FAIL disp_port: got en/we/addr %b%b/%h expected 10/005", mem_en_o, mem_we_o, mem_addr_o); end
            end
            n_checks++; if (disp_valid_o !== (k == 2)) begin
                n_errors++; $display("FAIL disp_valid k=%0d: got %b expected %b", k, disp_valid_o, k == 2); end
            if (k == 2) begin
                n_checks++; if (disp_data_o !== 8'h41) begin n_errors++; $display("FAIL disp_data: got %h expected 41", disp_data_o); end
            end
        end
    endtask

    task automatic test_bus_write_read();
        for (int k = 0; k < 9; k++) begin
            run_cycle(1'b0, 1'b0, '0, (k == 0) || (k == 4), k == 0, 12'h083, 8'h5A);
            if (k == 0) begin
                n_checks++; if (bus_ready_o !== 1'b1) begin n_errors++; $display("FAIL wr_ready: got %b expected 1", bus_ready_o); end
            end
            if (k == 1) begin
                n_checks++; if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {2'b11, 12'h083, 8'h5A}) begin
                    n_errors++; $display("FAIL wr_issue: got en/we/addr/data %b%b/%h/%h expected 11/083/5a", mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o); end
            end
            if (k == 5) begin
                n_checks++; if ({mem_en_o, mem_we_o, mem_addr_o} !== {2'b10, 12'h083}) begin
                    n_errors++; $display("FAIL rd_issue: got en/we/addr %b%b/%h expected 10/083", mem_en_o, mem_we_o, mem_addr_o); end
            end
            n_checks++; if ({bus_done_o, bus_err_o} !== {(k == 3) || (k == 7), 1'b0}) begin
                n_errors++; $display("FAIL wr_rd_done k=%0d: got done/err %b%b expected %b0", k, bus_done_o, bus_err_o, (k == 3) || (k == 7)); end
            if (k == 7) begin
                n_checks++; if (bus_rdata_o !== 8'h5A) begin n_errors++; $display("FAIL rd_data: got %h expected 5a", bus_rdata_o); end
            end
        end
    endtask

    task automatic test_disp_priority();
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, AW'(12'h100 + i), DW'(8'hC0 + i));
            idle(1);
        end
        idle(3);
        for (int k = 0; k < 12; k++) begin
            run_cycle(1'b0, k < 8, AW'(12'h100 + k), k == 0, 1'b0, 12'h083, '0);
            if (k < 8) begin
                n_checks++; if ({mem_we_o, mem_addr_o} !== {1'b0, AW'(12'h100 + k)}) begin
                    n_errors++; $display("FAIL prio_port k=%0d: got we/addr %b/%h expected 0/%h", k, mem_we_o, mem_addr_o, AW'(12'h100 + k)); end
            end
            if (k == 8) begin
                n_checks++; if ({mem_en_o, mem_we_o, mem_addr_o} !== {2'b10, 12'h083}) begin
                    n_errors++; $display("FAIL prio_issue: got en/we/addr %b%b/%h expected 10/083", mem_en_o, mem_we_o, mem_addr_o); end
            end
            n_checks++; if (disp_valid_o !== (k >= 2 && k <= 9)) begin
                n_errors++; $display("FAIL prio_valid k=%0d: got %b expected %b", k, disp_valid_o, k >= 2 && k <= 9); end
            if (k >= 2 && k <= 9) begin
                n_checks++; if (disp_data_o !== DW'(8'hC0 + k - 2)) begin
                    n_errors++; $display("FAIL prio_data k=%0d: got %h expected %h", k, disp_data_o, DW'(8'hC0 + k - 2)); end
            end
            n_checks++; if (bus_done_o !== (k == 10)) begin
                n_errors++; $display("FAIL prio_done k=%0d: got %b expected %b", k, bus_done_o, k == 10); end
            if (k == 10) begin
                n_checks++; if (bus_rdata_o !== 8'h5A) begin n_errors++; $display("FAIL prio_rdata: got %h expected 5a", bus_rdata_o); end
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < 10; k++) begin
            run_cycle(1'b0, 1'b0, '0, (k == 0) || (k == 5), k == 0, (k == 0) ? 12'hF00 : 12'h050, 8'h77);
            if (k == 1 || k == 6) begin
                n_checks++; if (mem_en_o !== 1'b0) begin n_errors++; $display("FAIL oor_mem_en k=%0d: got %b expected 0", k, mem_en_o); end
            end
            n_checks++; if ({bus_done_o, bus_err_o} !== {2{(k == 3) || (k == 8)}}) begin
                n_errors++; $display("FAIL oor_done_err k=%0d: got %b%b expected %b%b", k, bus_done_o, bus_err_o, (k == 3) || (k == 8), (k == 3) || (k == 8)); end
            if (k == 3 || k == 8) begin
                n_checks++; if (bus_rdata_o !== 8'h00) begin n_errors++; $display("FAIL oor_rdata k=%0d: got %h expected 00", k, bus_rdata_o); end
            end
        end
        n_checks++; if (ram[12'hF00] !== pattern(12'hF00)) begin
            n_errors++; $display("FAIL oor_ram: got %h expected %h", ram[12'hF00], pattern(12'hF00)); end
    endtask

    task automatic test_starve();
        for (int k = 0; k < 26; k++) begin
            run_cycle(1'b0, k < 20, AW'(12'h200 + k), k == 0, 1'b0, 12'h005, '0);
            if (k <= 16 || k >= 17) begin
                n_checks++; if (bus_starve_o !== (k >= 17)) begin
                    n_errors++; $display("FAIL starve k=%0d: got %b expected %b", k, bus_starve_o, k >= 17); end
            end
            if (k == 20) begin
                n_checks++; if ({mem_en_o, mem_we_o, mem_addr_o} !== {2'b10, 12'h005}) begin
                    n_errors++; $display("FAIL starve_issue: got en/we/addr %b%b/%h expected 10/005", mem_en_o, mem_we_o, mem_addr_o); end
            end
            if (k == 22) begin
                n_checks++; if ({bus_done_o, bus_rdata_o} !== {1'b1, 8'h41}) begin
                    n_errors++; $display("FAIL starve_done: got %b/%h expected 1/41", bus_done_o, bus_rdata_o); end
            end
        end
    endtask

    task automatic test_reset_inflight();
        for (int k = 0; k < 8; k++) begin
            run_cycle(k == 2, 1'b0, '0, k == 0, 1'b0, 12'h005, '0);
            if (k == 1) begin
                n_checks++; if ({mem_en_o, mem_we_o, mem_addr_o} !== {2'b10, 12'h005}) begin
                    n_errors++; $display("FAIL inflight_issue: got en/we/addr %b%b/%h expected 10/005", mem_en_o, mem_we_o, mem_addr_o); end
            end
            if (k >= 3) begin
                n_checks++; if ({bus_done_o, disp_valid_o} !== 2'b00) begin
                    n_errors++; $display("FAIL inflight_done k=%0d: got done/valid %b%b expected 00", k, bus_done_o, disp_valid_o); end
            end
            if (k == 3) begin
                n_checks++; if ({bus_ready_o, bus_starve_o} !== 2'b10) begin
                    n_errors++; $display("FAIL inflight_ready: got ready/starve %b%b expected 10", bus_ready_o, bus_starve_o); end
            end
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 5) return {5'($urandom_range(0, 1)), 7'($urandom_range(0, 3))};
        if (sel == 9) begin
            if ($urandom_range(0, 1) == 0) return {5'($urandom_range(30, 31)), 7'($urandom_range(0, 127))};
            return {5'($urandom_range(0, 31)), 7'($urandom_range(80, 127))};
        end
        return {5'($urandom_range(0, 29)), 7'($urandom_range(0, 79))};
    endfunction

    task automatic test_random();
        int            burst;
        logic          r, dq, bq, bw;
        logic [AW-1:0] da, ba;
        logic [DW-1:0] bd;
        burst = 0;
        for (int i = 0; i < 1500; i++) begin
            if (burst == 0 && $urandom_range(0, 99) == 0) burst = 20;
            dq = (burst > 0) || ($urandom_range(0, 99) < 40);
            if (burst > 0) burst--;
            r  = ($urandom_range(0, 199) == 0);
            bq = ($urandom_range(0, 99) < 40);
            bw = ($urandom_range(0, 1) == 1);
            da = rand_addr();
            ba = rand_addr();
            bd = DW'($urandom);
            run_cycle(r, dq, da, bq, bw, ba, bd);
            n_checks++; if (bus_ready_o !== e_ready) begin n_errors++; $display("FAIL rnd_ready c=%0d: got %b expected %b", cyc, bus_ready_o, e_ready); end
            n_checks++; if (mem_en_o !== e_mem_en) begin n_errors++; $display("FAIL rnd_mem_en c=%0d: got %b expected %b", cyc, mem_en_o, e_mem_en); end
            n_checks++; if (mem_we_o !== e_mem_we) begin n_errors++; $display("FAIL rnd_mem_we c=%0d: got %b expected %b", cyc, mem_we_o, e_mem_we); end
            if (e_mem_en) begin
                n_checks++; if (mem_addr_o !== e_mem_addr) begin n_errors++; $display("FAIL rnd_mem_addr c=%0d: got %h expected %h", cyc, mem_addr_o, e_mem_addr); end
            end
            if (e_mem_we) begin
                n_checks++; if (mem_wdata_o !== e_mem_wdata) begin n_errors++; $display("FAIL rnd_mem_wdata c=%0d: got %h expected %h", cyc, mem_wdata_o, e_mem_wdata); end
            end
            n_checks++; if (disp_valid_o !== e_disp_valid) begin n_errors++; $display("FAIL rnd_disp_valid c=%0d: got %b expected %b", cyc, disp_valid_o, e_disp_valid); end
            n_checks++; if (disp_data_o !== e_disp_data) begin n_errors++; $display("FAIL rnd_disp_data c=%0d: got %h expected %h", cyc, disp_data_o, e_disp_data); end
            n_checks++; if (bus_done_o !== e_done) begin n_errors++; $display("FAIL rnd_done c=%0d: got %b expected %b", cyc, bus_done_o, e_done); end
            n_checks++; if (bus_err_o !== e_err) begin n_errors++; $display("FAIL rnd_err c=%0d: got %b expected %b", cyc, bus_err_o, e_err); end
            n_checks++; if (bus_rdata_o !== e_rdata) begin n_errors++; $display("FAIL rnd_rdata c=%0d: got %h expected %h", cyc, bus_rdata_o, e_rdata); end
            n_checks++; if (bus_starve_o !== e_starve) begin n_errors++; $display("FAIL rnd_starve c=%0d: got %b expected %b", cyc, bus_starve_o, e_starve); end
        end
    endtask

    initial begin
        rst_i = 1'b1; disp_req_i = 1'b0; disp_addr_i = '0;
        bus_req_i = 1'b0; bus_we_i = 1'b0; bus_addr_i = '0; bus_wdata_i = '0;
        cyc = 0; n_checks = 0; n_errors = 0;
        m_pend = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        m_disp_last = '0; m_rdata_last = '0; m_cnt = 0; m_starve = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = pattern(i);

        test_reset();
        test_disp_read();
        test_bus_write_read();
        test_disp_priority();
        test_out_of_range();
        test_starve();
        test_reset_inflight();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vgachargen_map_arbiter.md
VGACHARGEN_MAP_ARBITER -- requirements
Module: vgachargen_map_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default vgachargen_pkg::CH_MAP_ADDR_WIDTH (12), map address {row[4:0], col[6:0]}.
REQ-002 SHALL have parameter DATA_W, default vgachargen_pkg::COL_MAP_DATA_WIDTH (8), map word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 16, number of bus-pending cycles before the starve flag sets.
REQ-004 SHALL use one clock; reset is synchronous and active-high. Ports are clk_i (input, 1, clock) and rst_i (input, 1, synchronous active-high reset).
REQ-005 SHALL have port disp_req_i (input, 1): display fetch request pulse.
REQ-006 SHALL have port disp_addr_i (input, ADDR_W): display fetch address.
REQ-007 SHALL have ports disp_valid_o (output, 1) and disp_data_o (output, DATA_W): display read return.
REQ-008 SHALL have ports bus_req_i (input, 1), bus_we_i (input, 1), bus_addr_i (input, ADDR_W) and bus_wdata_i (input, DATA_W): bus request.
REQ-009 SHALL have port bus_ready_o (output, 1): bus request accepted when high together with bus_req_i.
REQ-010 SHALL have ports bus_done_o (output, 1), bus_rdata_o (output, DATA_W) and bus_err_o (output, 1): bus completion.
REQ-011 SHALL have port bus_starve_o (output, 1): sticky starvation flag.
REQ-012 SHALL have ports mem_en_o (output, 1), mem_we_o (output, 1), mem_addr_o (output, ADDR_W), mem_wdata_o (output, DATA_W) and mem_rdata_i (input, DATA_W): single-port synchronous RAM with 1-cycle read latency.

Function
REQ-013 SHALL give display absolute priority: a cycle with disp_req_i=1 drives mem_en_o=1, mem_we_o=0 and mem_addr_o=disp_addr_i combinationally in the same cycle.
REQ-014 SHALL return display data with fixed latency: disp_req_i in cycle N gives disp_valid_o=1 for one cycle at N+2, with disp_data_o = RAM[disp_addr_i].
REQ-015 SHALL hold at most one bus request in a holding register; bus_ready_o = ~hold_valid.
REQ-016 SHALL issue a held request in the first cycle that has disp_req_i=0. Issue is never in the acceptance cycle, so the earliest issue is at acceptance +1.
REQ-017 SHALL, at issue, drive mem_en_o=1, mem_we_o=bus_we_i as captured, and the captured address and wdata; hold_valid clears in the same cycle.
REQ-018 SHALL pulse bus_done_o exactly once per accepted request, at issue+2; for reads, bus_rdata_o = RAM[addr] in that cycle.
REQ-019 SHALL treat an address with col>=80 (CH_H_PIXELS) or row>=30 (CH_V_PIXELS) as out of range. It issues with mem_en_o=0, completes at issue+2 with bus_err_o=1 and bus_rdata_o=0, and the RAM is unchanged.
REQ-020 SHALL assert bus_err_o only together with bus_done_o; otherwise it is 0.
REQ-021 SHALL tag each issued access (DISP, BUS_RD, BUS_WR, BUS_ERR, NONE) through a 2-stage tag pipeline. Return is steered only by the tag, never by current inputs.
REQ-022 SHALL count consecutive cycles with hold_valid=1 and no issue. When the count reaches STARVE_LIMIT, bus_starve_o sets and stays set until reset. The counter saturates and clears on issue.
REQ-023 SHALL keep bus_rdata_o and disp_data_o at their last value when not valid.
REQ-024 SHALL, in a cycle with disp_req_i and bus_req_i both high and hold empty, accept the bus request and serve the display; the bus issues at the next display-free cycle.
REQ-025 SHALL never assert mem_we_o in a cycle where disp_req_i=1.

Reset
REQ-026 SHALL, on rst_i=1, clear hold_valid, the tag pipeline, the starve counter and bus_starve_o.
REQ-027 SHALL hold disp_valid_o, bus_done_o, bus_err_o, disp_data_o and bus_rdata_o at 0 during reset.
REQ-028 SHALL, while rst_i=1, hold bus_ready_o=0 and mem_en_o=0.
REQ-029 SHALL discard in-flight accesses at reset: no valid or done pulse appears after reset for a request issued before it.

Structure
REQ-030 SHALL add to vgachargen_pkg: CH_MAP_DEPTH (CH_H_PIXELS*CH_V_PIXELS), a typedef map_arb_tag_e for the tag enum, and the default STARVE_LIMIT.
REQ-031 SHALL contain no sub-module; the RAM is instantiated outside the block.

Verification
REQ-032 SHALL check: disp_req_i at cycle 10 with addr 0x005 and RAM=0x41 -> disp_valid_o=1 and disp_data_o=0x41 at cycle 12 only.
REQ-033 SHALL check: bus write addr 0x083, data 0x5A, accepted at cycle 5 with no display traffic -> mem_we_o at 6, bus_done_o at 8; a following read returns 0x5A with bus_err_o=0.
REQ-034 SHALL check: disp_req_i high cycles 20-27 with a bus read accepted at 20 -> issue at 28, bus_done_o at 30, all 8 display returns at 22-29.
REQ-035 SHALL check: bus write addr {row=30, col=0} -> mem_en_o never high for it; bus_done_o=1 and bus_err_o=1 at issue+2; RAM unchanged.
REQ-036 SHALL check: continuous disp_req_i for 16 cycles with a held bus request -> bus_starve_o rises and stays 1 after display traffic stops.
REQ-037 SHALL check: rst_i pulsed the cycle after a bus read issue -> no bus_done_o, bus_ready_o=1 the cycle after reset deasserts.
